lfsr_gen: RTL

//   Parametrised maximal-length LFSR pseudo-random source: width 3..16, Fibonacci or Galois form,
//   run-time seed load with zero-seed protection, period/wrap detection and a counted burst mode.

---
 rtl/lfsr_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// Maximal-length LFSR source (Fibonacci or Galois) with seed load, wrap detection
// and a counted burst mode. All outputs are registered in a single clock domain.
module lfsr_gen #(
  parameter int WIDTH    = 10,
  parameter int MODE     = 0,
  parameter int SEED_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [WIDTH-1:0] len,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             seed_zero,
  output logic [WIDTH-1:0] period_cnt
);

  // Tap t of the primitive polynomial maps to mask bit t-1.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      MASK16 = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] MASK   = MASK16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_T = SEED_RST[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..16");
  end
  if (SEED_T == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED_RST truncated to WIDTH must be nonzero");
  end

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    if (MODE == 0) return {s[WIDTH-2:0], ^(s & MASK)};
    else           return (s >> 1) ^ (s[0] ? MASK : '0);
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] out_n, aseed, aseed_n, pcnt_n, rem, rem_n, nxt;
  logic             valid_n, busy_n, done_n, wrap_n, sz_n, do_step;

  assign nxt = lfsr_step(out);

  always_comb begin
    state_n = state;
    out_n   = out;
    aseed_n = aseed;
    pcnt_n  = period_cnt;
    rem_n   = rem;
    valid_n = 1'b0;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    sz_n    = 1'b0;
    do_step = 1'b0;
    if (load) begin
      // A zero seed would lock the register; substitute 1 and flag it.
      out_n   = (seed == '0) ? ONE : seed;
      aseed_n = out_n;
      pcnt_n  = '0;
      sz_n    = (seed == '0);
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_n = 1'b1;
            end else begin
              state_n = RUN;
              rem_n   = len;
            end
          end else if (en) begin
            do_step = 1'b1;
          end
        end
        RUN: begin
          do_step = 1'b1;
          rem_n   = rem - 1'b1;
          if (rem == ONE) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (do_step) begin
      out_n   = nxt;
      valid_n = 1'b1;
      if (nxt == aseed) begin
        wrap_n = 1'b1;
        pcnt_n = '0;
      end else begin
        pcnt_n = period_cnt + 1'b1;
      end
    end
    busy_n = (state_n == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out        <= SEED_T;
      aseed      <= SEED_T;
      period_cnt <= '0;
      rem        <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
      seed_zero  <= 1'b0;
    end else begin
      state      <= state_n;
      out        <= out_n;
      aseed      <= aseed_n;
      period_cnt <= pcnt_n;
      rem        <= rem_n;
      valid      <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
      wrap       <= wrap_n;
      seed_zero  <= sz_n;
    end
  end

endmodule
